// File: rtl/pciecfg_cfg_responder.sv
// NetTLP config-protocol responder: pops decoded config requests, runs them on the
// PCIe cfg_mgmt port and returns exactly one response per valid request.
module pciecfg_cfg_responder #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic        pcie_clk,
  input  logic        pcie_rst_n,
  input  logic        req_empty,
  input  logic [64:0] req_dout,
  output logic        req_rd_en,
  output logic [9:0]  cfg_mgmt_dwaddr,
  output logic [3:0]  cfg_mgmt_byte_en,
  output logic [31:0] cfg_mgmt_di,
  output logic        cfg_mgmt_wr_en,
  output logic        cfg_mgmt_rd_en,
  output logic        cfg_mgmt_wr_readonly,
  output logic        cfg_mgmt_wr_rw1c_as_rw,
  input  logic [31:0] cfg_mgmt_do,
  input  logic        cfg_mgmt_rd_wr_done,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_pkt,
  output logic        resp_err,
  output logic [15:0] stat_drop_cnt,
  output logic [15:0] stat_err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [TW-1:0] tmo_cnt_r;
  logic          pop_s, req_valid_s, bad_op_s, wr_nomask_s, tmo_s, hs_s, rd_op_r;

  // Disabled byte lanes of a read come back as zero.
  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction

  assign pop_s       = (state_r == IDLE) && !req_empty && pcie_rst_n;
  assign req_rd_en   = pop_s;
  assign req_valid_s = req_dout[64];
  assign bad_op_s    = req_dout[47];
  assign wr_nomask_s = (req_dout[47:46] == 2'b01) && (req_dout[45:42] == 4'b0000);
  assign tmo_s       = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 2));
  assign hs_s        = resp_valid && resp_ready;

  assign cfg_mgmt_wr_readonly   = 1'b0;
  assign cfg_mgmt_wr_rw1c_as_rw = 1'b0;

  // State register.
  always_ff @(posedge pcie_clk) begin
    if (!pcie_rst_n) state_r <= IDLE;
    else             state_r <= state_nxt_s;
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s && req_valid_s) begin
          if (bad_op_s || wr_nomask_s) state_nxt_s = RESP;
          else                         state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (cfg_mgmt_rd_wr_done || tmo_s) state_nxt_s = RESP;
        else                              state_nxt_s = ACCESS;
      end
      RESP: begin
        if (hs_s) state_nxt_s = IDLE;
        else      state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: resp_pkt doubles as the request register while the access runs.
  always_ff @(posedge pcie_clk) begin
    if (!pcie_rst_n) begin
      cfg_mgmt_dwaddr  <= 10'd0;
      cfg_mgmt_byte_en <= 4'd0;
      cfg_mgmt_di      <= 32'd0;
      cfg_mgmt_rd_en   <= 1'b0;
      cfg_mgmt_wr_en   <= 1'b0;
      rd_op_r          <= 1'b0;
      tmo_cnt_r        <= '0;
      resp_valid       <= 1'b0;
      resp_pkt         <= 64'd0;
      resp_err         <= 1'b0;
      stat_drop_cnt    <= 16'd0;
      stat_err_cnt     <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            if (!req_valid_s) begin
              if (stat_drop_cnt != 16'hFFFF) stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end else begin
              resp_pkt  <= req_dout[63:0];
              tmo_cnt_r <= '0;
              rd_op_r   <= (req_dout[47:46] == 2'b00);
              if (bad_op_s) begin
                resp_pkt[31:0] <= ERR_DATA;
                resp_err       <= 1'b1;
                resp_valid     <= 1'b1;
              end else if (wr_nomask_s) begin
                resp_err   <= 1'b0;
                resp_valid <= 1'b1;
              end else begin
                resp_err         <= 1'b0;
                cfg_mgmt_dwaddr  <= req_dout[41:32];
                cfg_mgmt_byte_en <= req_dout[45:42];
                cfg_mgmt_di      <= req_dout[31:0];
                cfg_mgmt_rd_en   <= (req_dout[47:46] == 2'b00);
                cfg_mgmt_wr_en   <= (req_dout[47:46] == 2'b01);
              end
            end
          end
        end
        ACCESS: begin
          if (cfg_mgmt_rd_wr_done) begin
            cfg_mgmt_rd_en <= 1'b0;
            cfg_mgmt_wr_en <= 1'b0;
            resp_valid     <= 1'b1;
            if (rd_op_r) resp_pkt[31:0] <= mask_bytes(cfg_mgmt_do, resp_pkt[45:42]);
          end else if (tmo_s) begin
            cfg_mgmt_rd_en <= 1'b0;
            cfg_mgmt_wr_en <= 1'b0;
            resp_valid     <= 1'b1;
            resp_err       <= 1'b1;
            resp_pkt[31:0] <= ERR_DATA;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        RESP: begin
          if (hs_s) begin
            resp_valid <= 1'b0;
            if (resp_err && (stat_err_cnt != 16'hFFFF)) stat_err_cnt <= stat_err_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pciecfg_cfg_responder.sv
// Self-checking bench for pciecfg_cfg_responder: directed scenarios plus random
// requests compared against a request-level reference model.
module tb_pciecfg_cfg_responder;
  localparam int          TO   = 16;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req_empty, req_rd_en;
  logic [64:0] req_dout;
  logic [9:0]  cfg_mgmt_dwaddr;
  logic [3:0]  cfg_mgmt_byte_en;
  logic [31:0] cfg_mgmt_di, cfg_mgmt_do;
  logic        cfg_mgmt_wr_en, cfg_mgmt_rd_en, cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw;
  logic        cfg_mgmt_rd_wr_done;
  logic        resp_valid, resp_err;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_pkt;
  logic [15:0] stat_drop_cnt, stat_err_cnt;

  int checks = 0;
  int errors = 0;

  pciecfg_cfg_responder #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)) dut (
    .pcie_clk(clk), .pcie_rst_n(rst_n), .req_empty(req_empty), .req_dout(req_dout),
    .req_rd_en(req_rd_en), .cfg_mgmt_dwaddr(cfg_mgmt_dwaddr), .cfg_mgmt_byte_en(cfg_mgmt_byte_en),
    .cfg_mgmt_di(cfg_mgmt_di), .cfg_mgmt_wr_en(cfg_mgmt_wr_en), .cfg_mgmt_rd_en(cfg_mgmt_rd_en),
    .cfg_mgmt_wr_readonly(cfg_mgmt_wr_readonly), .cfg_mgmt_wr_rw1c_as_rw(cfg_mgmt_wr_rw1c_as_rw),
    .cfg_mgmt_do(cfg_mgmt_do), .cfg_mgmt_rd_wr_done(cfg_mgmt_rd_wr_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pkt(resp_pkt), .resp_err(resp_err),
    .stat_drop_cnt(stat_drop_cnt), .stat_err_cnt(stat_err_cnt));

  // FWFT request FIFO: the initial block owns the write side, the pop process the read side.
  logic [64:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  assign req_empty = (wr_ptr == rd_ptr);
  assign req_dout  = req_empty ? 65'd0 : fifo_mem[rd_ptr % 64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_rd_en) rd_ptr <= rd_ptr + 1;
  end

  // cfg_mgmt model: done after cfg_lat strobe cycles (0 = never), plus a forced done.
  int          cfg_lat = 0;
  int          strobe_cyc = 0;
  logic [31:0] cfg_do_v = 32'd0;
  logic        force_done = 1'b0;
  assign cfg_mgmt_do = cfg_do_v;
  assign cfg_mgmt_rd_wr_done = ((cfg_mgmt_rd_en || cfg_mgmt_wr_en) && (cfg_lat != 0) &&
                                (strobe_cyc == cfg_lat - 1)) || force_done;
  always @(posedge clk) begin
    if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) strobe_cyc <= strobe_cyc + 1;
    else                                  strobe_cyc <= 0;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitors: access windows, responses, pops, handshakes, stall stability.
  logic [64:0] resp_q [$];
  int          len_q [$];
  logic [47:0] info_q [$];
  int          acc_start_q [$];
  int          pop_q [$];
  int          hs_q [$];
  logic        in_acc = 1'b0;
  int          acc_len = 0;
  logic [47:0] held_info;
  logic        stall_prev = 1'b0;
  logic [64:0] stall_hold;

  always @(negedge clk) begin
    logic [47:0] cur;
    cur = {cfg_mgmt_rd_en, cfg_mgmt_wr_en, cfg_mgmt_dwaddr, cfg_mgmt_byte_en, cfg_mgmt_di};
    if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
      if (!in_acc) begin
        in_acc = 1'b1; acc_len = 0; held_info = cur;
        info_q.push_back(cur); acc_start_q.push_back(cyc);
      end else begin
        check("strobe_stable", cur, held_info);
      end
      acc_len++;
    end else if (in_acc) begin
      in_acc = 1'b0;
      len_q.push_back(acc_len);
    end
    if (req_rd_en) begin
      check("pop_nonempty", req_empty, 1'b0);
      pop_q.push_back(cyc);
    end
    if (stall_prev) begin
      check("stall_valid", resp_valid, 1'b1);
      check("stall_pkt", {resp_err, resp_pkt}, stall_hold);
    end
    stall_prev = resp_valid && !resp_ready;
    stall_hold = {resp_err, resp_pkt};
    if (resp_valid && resp_ready) begin
      resp_q.push_back({resp_err, resp_pkt});
      hs_q.push_back(cyc);
    end
  end

  // Reference model at request level.
  function automatic logic [64:0] model_resp(input logic [64:0] req, input int lat, input logic [31:0] dov);
    logic [1:0]  op;
    logic [3:0]  m;
    logic [31:0] d;
    logic        e;
    op = req[47:46]; m = req[45:42]; d = req[31:0]; e = 1'b0;
    if (op >= 2'd2) begin
      d = ERRD; e = 1'b1;
    end else if (op == 2'd1 && m == 4'd0) begin
      d = req[31:0];
    end else if (lat < 1 || lat > TO - 1) begin
      d = ERRD; e = 1'b1;
    end else if (op == 2'd0) begin
      d = 32'd0;
      for (int i = 0; i < 4; i++) if (m[i]) d = d + (dov & (32'hFF << (8 * i)));
    end
    return {e, req[63:32], d};
  endfunction

  function automatic int model_len(input logic [64:0] req, input int lat);
    if (req[47] || (req[47:46] == 2'd1 && req[45:42] == 4'd0)) return 0;
    if (lat >= 1 && lat <= TO - 1) return lat;
    return TO - 1;
  endfunction

  function automatic logic [64:0] mk(input logic dv, input logic [15:0] udp, input logic [1:0] op,
                                     input logic [3:0] m, input logic [9:0] a, input logic [31:0] d);
    return {dv, udp, op, m, a, d};
  endfunction

  task automatic push(input logic [64:0] x);
    fifo_mem[wr_ptr % 64] = x;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_resp(output logic [64:0] r);
    int n;
    n = 0;
    while (resp_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrives", resp_q.size() > 0, 1'b1);
    if (resp_q.size() > 0) r = resp_q.pop_front();
    else                   r = 65'd0;
  endtask

  int exp_err = 0;
  int exp_drop = 0;

  task automatic run_one(input logic [64:0] req, input int lat, input logic [31:0] dov);
    logic [64:0] got, ex;
    int          el;
    @(posedge clk); #1;
    cfg_lat = lat; cfg_do_v = dov;
    push(req);
    if (!req[64]) begin
      exp_drop++;
      repeat (3) @(negedge clk);
      check("drop_noresp", resp_q.size(), 0);
      check("drop_cnt", stat_drop_cnt, exp_drop);
    end else begin
      wait_resp(got);
      ex = model_resp(req, lat, dov);
      check("resp", got, ex);
      el = model_len(req, lat);
      if (el == 0) begin
        check("no_access", len_q.size(), 0);
      end else begin
        check("acc_count", len_q.size(), 1);
        if (len_q.size() > 0) begin
          check("acc_len", len_q[0], el);
          check("acc_info", info_q[0], {req[47:46] == 2'd0, req[47:46] == 2'd1, req[41:32], req[45:42], req[31:0]});
        end
      end
      if (ex[64]) exp_err++;
      @(negedge clk);
      check("err_cnt", stat_err_cnt, exp_err);
    end
    len_q.delete(); info_q.delete(); acc_start_q.delete(); pop_q.delete(); hs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] r, a, b;
    int          n, lat;
    logic [1:0]  op;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outs", {req_rd_en, cfg_mgmt_rd_en, cfg_mgmt_wr_en, resp_valid, resp_err,
                       cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw}, 7'd0);
    check("rst_pkt", resp_pkt, 64'd0);
    check("rst_cnts", {stat_drop_cnt, stat_err_cnt}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; resp_ready = 1'b1;

    // RD with 3-cycle done; also pop-to-strobe latency.
    a = mk(1'b1, 16'hBEEF, 2'b00, 4'hF, 10'h000, 32'd0);
    @(posedge clk); #1;
    cfg_lat = 3; cfg_do_v = 32'h1234_10EE;
    push(a);
    wait_resp(r);
    check("rd_resp", r, {1'b0, 16'hBEEF, 2'b00, 4'hF, 10'h000, 32'h1234_10EE});
    check("rd_len", (len_q.size() == 1) ? len_q[0] : -1, 3);
    check("pop_to_strobe", (pop_q.size() == 1 && acc_start_q.size() == 1) ? acc_start_q[0] - pop_q[0] : -1, 1);
    len_q.delete(); info_q.delete(); acc_start_q.delete(); pop_q.delete(); hs_q.delete();

    // WR to BAR0 with 1-cycle done, then masked RD.
    run_one(mk(1'b1, 16'h0101, 2'b01, 4'b0011, 10'h004, 32'hF000_0000), 1, 32'd0);
    run_one(mk(1'b1, 16'h0202, 2'b00, 4'b0011, 10'h004, 32'd0), 2, 32'hAABB_CCDD);

    // Timeout.
    run_one(mk(1'b1, 16'h0303, 2'b00, 4'hF, 10'h010, 32'd0), 0, 32'h1111_2222);
    check("tmo_err_cnt", stat_err_cnt, 16'd1);

    // Drop, bad opcode, empty-mask write back to back.
    @(posedge clk); #1;
    a = mk(1'b1, 16'hA0A0, 2'b10, 4'h5, 10'h020, 32'h5555_5555);
    b = mk(1'b1, 16'hB0B0, 2'b01, 4'h0, 10'h030, 32'h0BAD_CAFE);
    push(mk(1'b0, 16'h9999, 2'b00, 4'hF, 10'h001, 32'd7));
    push(a); push(b);
    wait_resp(r);
    check("b2b_badop", r, model_resp(a, 0, 32'd0));
    wait_resp(r);
    check("b2b_wrnomask", r, model_resp(b, 0, 32'd0));
    exp_drop++; exp_err++;
    @(negedge clk);
    check("b2b_drop_cnt", stat_drop_cnt, exp_drop);
    check("b2b_err_cnt", stat_err_cnt, exp_err);
    check("b2b_no_access", len_q.size(), 0);
    len_q.delete(); info_q.delete(); acc_start_q.delete(); pop_q.delete(); hs_q.delete();

    // Response back-pressure with a second request queued.
    @(posedge clk); #1;
    resp_ready = 1'b0; cfg_lat = 2; cfg_do_v = 32'hCAFE_F00D;
    a = mk(1'b1, 16'h5151, 2'b00, 4'b1100, 10'h040, 32'd0);
    b = mk(1'b1, 16'h5252, 2'b01, 4'hF, 10'h044, 32'h1357_9BDF);
    push(a); push(b);
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("stall_one_pop", pop_q.size(), 1);
    check("stall_still_valid", resp_valid, 1'b1);
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_resp(r);
    check("stall_resp_a", r, model_resp(a, 2, 32'hCAFE_F00D));
    wait_resp(r);
    check("stall_resp_b", r, model_resp(b, 2, 32'hCAFE_F00D));
    check("pop_after_hs", (pop_q.size() == 2 && hs_q.size() >= 1) ? pop_q[1] - hs_q[0] : -1, 1);
    len_q.delete(); info_q.delete(); acc_start_q.delete(); pop_q.delete(); hs_q.delete();

    // Reset in the middle of an access, then a late done.
    @(posedge clk); #1;
    cfg_lat = 0;
    push(mk(1'b1, 16'h7777, 2'b00, 4'hF, 10'h050, 32'd0));
    n = 0;
    while (!cfg_mgmt_rd_en && n < 50) begin @(negedge clk); n++; end
    check("rst_acc_started", cfg_mgmt_rd_en, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; force_done = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {cfg_mgmt_rd_en, cfg_mgmt_wr_en, req_rd_en, resp_valid, resp_err}, 5'd0);
    check("midrst_pkt_cnts", {resp_pkt, stat_drop_cnt, stat_err_cnt}, 96'd0);
    repeat (3) @(negedge clk);
    check("midrst_noresp", resp_q.size(), 0);
    check("midrst_strobe_low", {cfg_mgmt_rd_en, cfg_mgmt_wr_en}, 2'd0);
    @(posedge clk); #1 force_done = 1'b0;
    len_q.delete(); info_q.delete(); acc_start_q.delete(); pop_q.delete(); hs_q.delete();
    exp_err = 0; exp_drop = 0;
    run_one(mk(1'b1, 16'h8888, 2'b00, 4'b1001, 10'h060, 32'd0), 4, 32'h1122_3344);

    // Random requests.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      if (n <= 3)      op = 2'b00;
      else if (n <= 7) op = 2'b01;
      else             op = 2'($urandom_range(2, 3));
      lat = $urandom_range(0, 17);
      run_one(mk((n != 9), 16'($urandom), op, 4'($urandom), 10'($urandom), $urandom), lat, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pciecfg_cfg_responder.md
Name: pciecfg_cfg_responder

Overview:
- Responder end of the NetTLP PCIe configuration protocol on UDP port 0x5001.
- Pops decoded config requests from the receive FIFO (FIFO_PCIECFG_T entries), executes each on the PCIe hard block's cfg_mgmt port, and emits one response entry per request to the UDP transmit path.
- Runs entirely in the PCIe user clock domain. The request and response FIFOs are external.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for cfg_mgmt_rd_wr_done before aborting an access. Must be ≥2.
- ERR_DATA, 32'hFFFF_FFFF: data returned on timeout or invalid opcode.

Ports:
- pcie_clk  in  1  PCIe user clock.
- pcie_rst_n  in  1  synchronous, active-low reset.
- req_empty  in  1  request FIFO empty. The FIFO is first-word-fall-through.
- req_dout  in  65  FIFO_PCIECFG_T: {data_valid, udp_check[15:0], opcode[1:0], byte_mask[3:0], dwaddr[9:0], data[31:0]}.
- req_rd_en  out  1  request FIFO pop strobe.
- cfg_mgmt_dwaddr  out  10  config dword address.
- cfg_mgmt_byte_en  out  4  write byte enables.
- cfg_mgmt_di  out  32  write data.
- cfg_mgmt_wr_en  out  1  write strobe, held until done.
- cfg_mgmt_rd_en  out  1  read strobe, held until done.
- cfg_mgmt_wr_readonly  out  1  constant 0.
- cfg_mgmt_wr_rw1c_as_rw  out  1  constant 0.
- cfg_mgmt_do  in  32  read data, valid when done=1.
- cfg_mgmt_rd_wr_done  in  1  access complete.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accepted.
- resp_pkt  out  64  {udp_check, opcode, byte_mask, dwaddr, data}, same packing as the request pkt field.
- resp_err  out  1  1 = timeout or invalid opcode.
- stat_drop_cnt  out  16  entries discarded because data_valid=0. Saturating.
- stat_err_cnt  out  16  error responses issued. Saturating.

Behaviour:
- Reset values: all outputs 0 (resp_pkt, resp_err, strobes, counters, req_rd_en). State returns to IDLE.
- Reset mid-access:
  - Strobes drop on the next edge.
  - The in-flight request is lost and no response is produced.
  - A late done after reset is ignored.
- IDLE, when !req_empty:
  - Pulse req_rd_en for exactly 1 cycle and latch req_dout into the request register.
  - data_valid=0: drop the entry, increment stat_drop_cnt, stay in IDLE.
  - opcode ∈ {2'b10, 2'b11}: go to RESP with data=ERR_DATA, err=1.
  - WR with byte_mask=4'b0000: go to RESP immediately. No cfg access; data echoes the request; err=0.
  - Otherwise go to ACCESS.
- req_rd_en never asserts while req_empty=1 and never asserts outside IDLE. At most one request is outstanding.
- ACCESS:
  - From the first cycle in ACCESS, drive dwaddr, byte_en=byte_mask, di=data, and rd_en (RD) or wr_en (WR).
  - Hold all of these stable until a cycle where cfg_mgmt_rd_wr_done=1. A done in the first ACCESS cycle is legal.
  - On done: deassert the strobe on the next edge and go to RESP.
  - RD response data: cfg_mgmt_do with bytes whose byte_mask bit is 0 forced to 0x00.
  - WR response data: echoes the request data.
  - Timeout counter clears on entry and increments each ACCESS cycle. Reaching TIMEOUT_CYCLES-1 without done: deassert the strobe, go to RESP with data=ERR_DATA, err=1.
  - done asserted on the timeout cycle itself counts as success.
- RESP:
  - resp_valid=1 with resp_pkt/resp_err stable until resp_ready=1. Stalls of any length are allowed.
  - On the handshake cycle: go to IDLE, and increment stat_err_cnt if err=1.
  - The next pop can occur the cycle after the handshake. This guarantees ≥1 cycle of strobe-low between cfg accesses.
- Pass-through fields: udp_check, opcode, byte_mask and dwaddr are copied unchanged from request to response.
- Latency: pop to cfg strobe is 1 cycle. done to resp_valid is 1 cycle.
- Counters saturate at 16'hFFFF.

Test Plan:
- RD dwaddr=0x000, mask=4'hF, udp_check=0xBEEF; model returns do=0x1234_10EE after 3 cycles → exactly one rd_en period of 3 cycles; resp_pkt={0xBEEF, 00, F, 0x000, 0x1234_10EE}; err=0.
- WR dwaddr=0x004 (BAR0), mask=4'b0011, data=0xF000_0000; done at 1 cycle → wr_en=1, byte_en=0011, di=0xF000_0000 held 1 cycle; response echoes the data; err=0. Follow with RD mask=4'b0011, do=0xAABB_CCDD → resp data=0x0000_CCDD.
- Model never asserts done on RD with TIMEOUT_CYCLES=16 → rd_en drops after 15 cycles; resp data=0xFFFF_FFFF, err=1; stat_err_cnt=1.
- Entries {data_valid=0}, {opcode=2'b10}, {WR mask=0} back-to-back with resp_ready=1 → stat_drop_cnt=1; two responses: first err=1, second err=0 with no cfg strobe.
- resp_ready held 0 for 20 cycles with a second request queued → resp_pkt stable; req_rd_en stays 0; the second pop occurs the cycle after the handshake.
- Assert pcie_rst_n=0 for 1 cycle mid-ACCESS, then return done=1 → strobes 0 the next cycle; no response issued; outputs at reset values; the next request proceeds normally.
